// File: rtl/mux_scan_packer_pkg.sv
// Shared types and helpers for the 4:1 mux scan packer.
// Select encoding of the channel mux lives here so every driver agrees.
package mux_scan_packer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_e;

  localparam logic [1:0] SEL_PARK = 2'b11;

  function automatic logic [1:0] ch_to_sel(
    input logic [1:0] k
  );
    return 2'd3 - k;
  endfunction

endpackage

// File: rtl/mux_scan_packer.sv
// Scans a 4:1 channel mux, packs four samples into one word and
// hands it off on a valid/ready handshake.
module mux_scan_packer
  import mux_scan_packer_pkg::*;
#(
  parameter int DATA_W     = 2,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     mux_out_i,
  output logic [1:0]            sel_o,
  output logic [4*DATA_W-1:0]   word_o,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  busy,
  output logic [3:0]            scan_cnt
);

  state_e                   state_q;
  logic [1:0]               idx_q;
  logic [3:0][DATA_W-1:0]   shadow_q;
  logic [3:0][DATA_W-1:0]   shadow_d;
  logic [1:0]               sel_q;
  logic [4*DATA_W-1:0]      word_q;
  logic                     valid_q;
  logic                     busy_q;
  logic [3:0]               cnt_q;

  // Current sample merged in so the last slot lands in word_q at once
  always_comb begin
    shadow_d        = shadow_q;
    shadow_d[idx_q] = mux_out_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      sel_q    <= SEL_PARK;
      word_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          sel_q <= SEL_PARK;
          if (start) begin
            state_q <= SCAN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          shadow_q <= shadow_d;
          idx_q    <= idx_q + 2'd1;
          sel_q    <= ch_to_sel(idx_q + 2'd1);
          if (idx_q == 2'd3) begin
            word_q  <= shadow_d;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (word_ready) begin
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + 4'd1;
            if (CONTINUOUS || start) begin
              state_q <= SCAN;
              idx_q   <= '0;
              sel_q   <= SEL_PARK;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel_o      = sel_q;
  assign word_o     = word_q;
  assign word_valid = valid_q;
  assign busy       = busy_q;
  assign scan_cnt   = cnt_q;

endmodule

// File: tb/tb_mux_scan_packer.sv
// Bench for mux_scan_packer: one-shot and continuous instances
// against a phase-level reference model.
module tb_mux_scan_packer;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      st = '0;
  logic [1:0]      rdy = '0;
  logic [1:0]      vld;
  logic [1:0]      bsy;
  logic [1:0][1:0] sel;
  logic [1:0][1:0] mo;
  logic [1:0][7:0] word;
  logic [1:0][3:0] cnt;
  logic [1:0]      dv [4];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // channel mux partner: sel = 3 - k picks channel k
  always_comb begin
    mo[0] = dv[2'd3 - sel[0]];
    mo[1] = dv[2'd3 - sel[1]];
  end

  mux_scan_packer #(.DATA_W(2), .CONTINUOUS(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .mux_out_i(mo[0]),
    .sel_o(sel[0]), .word_o(word[0]), .word_valid(vld[0]),
    .word_ready(rdy[0]), .busy(bsy[0]), .scan_cnt(cnt[0])
  );

  mux_scan_packer #(.DATA_W(2), .CONTINUOUS(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .mux_out_i(mo[1]),
    .sel_o(sel[1]), .word_o(word[1]), .word_valid(vld[1]),
    .word_ready(rdy[1]), .busy(bsy[1]), .scan_cnt(cnt[1])
  );

  // model: ph = -1 idle, 0..3 next channel to sample, 4 word held
  int         ph [2];
  logic [1:0] smp [2][4];
  logic [7:0] mw [2];
  logic [3:0] mc [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        ph[i] <= -1;
        mw[i] <= '0;
        mc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ph[i] == -1) begin
          if (st[i]) ph[i] <= 0;
        end else if (ph[i] < 4) begin
          smp[i][ph[i]] <= dv[ph[i]];
          ph[i] <= ph[i] + 1;
          if (ph[i] == 3)
            mw[i] <= {dv[3], smp[i][2], smp[i][1], smp[i][0]};
        end else if (rdy[i]) begin
          mc[i] <= mc[i] + 4'd1;
          ph[i] <= (i == 1 || st[i]) ? 0 : -1;
        end
      end
    end
  end

  function automatic logic [1:0] esel(input int p);
    if (p >= 0 && p < 4) return 2'(3 - p);
    return 2'b11;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h",
                  nm, $time, act, exp);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("sel[%0d]", i), 32'(sel[i]), 32'(esel(ph[i])));
        chk($sformatf("valid[%0d]", i), 32'(vld[i]), 32'(ph[i] == 4));
        chk($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(ph[i] != -1));
        chk($sformatf("word[%0d]", i), 32'(word[i]), 32'(mw[i]));
        chk($sformatf("cnt[%0d]", i), 32'(cnt[i]), 32'(mc[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_d(input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] c, input logic [1:0] d);
    dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = d;
  endtask

  task automatic wait_valid0(input string nm);
    int w;
    w = 0;
    while (!vld[0] && w < 12) begin
      tick();
      w++;
    end
    chk(nm, 32'(vld[0]), 32'd1);
  endtask

  initial begin
    set_d(2'b01, 2'b10, 2'b11, 2'b00);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_sel", 32'(sel[0]), 32'h3);
      chk("idle_cnt", 32'(cnt[0]), 32'h0);
    end

    // continuous: one word per 5 cycles, counter wraps after 16
    rdy[1] = 1'b1;
    st[1] = 1'b1;
    tick();
    st[1] = 1'b0;
    repeat (79) @(posedge clk);
    #2;
    chk("cont_cnt15", 32'(cnt[1]), 32'd15);
    tick();
    chk("cont_wrap", 32'(cnt[1]), 32'd0);
    rdy[1] = 1'b0;

    // single scan with literal sel sequence and latency
    rdy[0] = 1'b1;
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("seq_sel", 32'(sel[0]), 32'(3 - k));
      chk("seq_novalid", 32'(vld[0]), 32'd0);
      tick();
    end
    chk("single_valid", 32'(vld[0]), 32'd1);
    chk("single_word", 32'(word[0]), 32'h39);
    tick();
    chk("single_idle", 32'(bsy[0]), 32'd0);
    chk("single_cnt", 32'(cnt[0]), 32'd1);

    // back-pressure: word stays put while inputs wander
    rdy[0] = 1'b0;
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    wait_valid0("bp_valid");
    for (int k = 0; k < 6; k++) begin
      set_d(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      tick();
      chk("bp_word", 32'(word[0]), 32'h39);
      chk("bp_hold", 32'(vld[0]), 32'd1);
    end
    rdy[0] = 1'b1;
    tick();
    chk("bp_accept", 32'(vld[0]), 32'd0);
    chk("bp_cnt", 32'(cnt[0]), 32'd2);

    // random traffic on both instances
    for (int n = 0; n < 300; n++) begin
      set_d(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      st = 2'($urandom_range(0, 3) & {2{$urandom_range(0, 2) == 0}});
      rdy = 2'($urandom);
      tick();
    end

    // drain, then reset after the second capture
    st = '0;
    rdy = '1;
    repeat (12) tick();
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("rst_novalid", 32'(vld[0]), 32'd0);
      tick();
    end
    set_d(2'b11, 2'b00, 2'b01, 2'b10);
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    wait_valid0("rst_fresh_valid");
    chk("rst_fresh_word", 32'(word[0]), 32'h93);
    tick();

    // start held through the scan, then start with ready in HOLD
    rdy[0] = 1'b0;
    st[0] = 1'b1;
    tick();
    wait_valid0("held_valid");
    rdy[0] = 1'b1;
    tick();
    chk("restart_sel", 32'(sel[0]), 32'h3);
    chk("restart_busy", 32'(bsy[0]), 32'd1);
    chk("restart_valid", 32'(vld[0]), 32'd0);
    st[0] = 1'b0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
